fetch_if_stage: RTL and testbench

//   Instruction-fetch stage plus IF/ID pipeline register. Holds PC/nPC, drives instruction memory,
//   and loads fetched words into ID. Consumes stall_F/stall_D from the load-use hazard unit and

---
 rtl/fetch_if_stage.sv | 88 ++++++++
 tb/tb_fetch_if_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Tolerates imem wait states; a redirect or annul seen during a wait is held until the fetch completes.
module fetch_if_stage #(
   parameter int                 ADDR_W   = 32,
   parameter int                 INSTR_W  = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0,
   parameter logic [INSTR_W-1:0] NOP      = 32'h0100_0000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall_F,
   input  logic               stall_D,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_target,
   input  logic               annul,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ready,
   input  logic [INSTR_W-1:0] imem_instr,
   output logic [INSTR_W-1:0] instr_ID,
   output logic [ADDR_W-1:0]  pc_ID,
   output logic [ADDR_W-1:0]  npc_ID,
   output logic               valid_ID
);

   typedef enum logic {FETCH, WAIT} state_t;

   state_t             state;
   logic [ADDR_W-1:0]  pc;
   logic [ADDR_W-1:0]  npc;
   logic [ADDR_W-1:0]  redir_tgt;
   logic [ADDR_W-1:0]  new_pc;
   logic               redir_pend;
   logic               annul_pend;
   logic               hold;
   logic               done;
   logic               slot_live;

   // Either stall freezes the whole front end; ID re-presents branch/annul afterwards.
   assign hold      = stall_F | stall_D;
   assign imem_req  = rst_n & ~hold;
   assign done      = imem_req & imem_ready;
   assign imem_addr = pc;
   assign slot_live = ~(annul | annul_pend);
   assign new_pc    = branch_taken ? branch_target : (redir_pend ? redir_tgt : npc);

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc         <= RESET_PC;
         npc        <= RESET_PC + ADDR_W'(4);
         instr_ID   <= NOP;
         pc_ID      <= '0;
         npc_ID     <= '0;
         valid_ID   <= 1'b0;
         state      <= FETCH;
         redir_pend <= 1'b0;
         redir_tgt  <= '0;
         annul_pend <= 1'b0;
      end else if (!hold) begin
         if (done) begin
            instr_ID   <= slot_live ? imem_instr : NOP;
            pc_ID      <= pc;
            npc_ID     <= npc;
            valid_ID   <= slot_live;
            pc         <= new_pc;
            npc        <= new_pc + ADDR_W'(4);
            redir_pend <= 1'b0;
            annul_pend <= 1'b0;
         end else begin
            // Bubble into ID while memory is busy; pc_ID/npc_ID keep their last values.
            instr_ID <= NOP;
            valid_ID <= 1'b0;
            if (branch_taken) begin
               redir_pend <= 1'b1;
               redir_tgt  <= branch_target;
            end
            if (annul) annul_pend <= 1'b1;
         end
         case (state)
            FETCH:   if (!done) state <= WAIT;
            WAIT:    if (done)  state <= FETCH;
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_if_stage.sv
// Self-checking bench for fetch_if_stage: directed scenarios followed by random traffic,
// all compared against a per-cycle reference model of the fetch rules.
module tb_fetch_if_stage;

   localparam logic [31:0] NOP = 32'h0100_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall_F = 1'b0, stall_D = 1'b0, branch_taken = 1'b0, annul = 1'b0;
   logic [31:0] branch_target = '0;
   logic        imem_req, imem_ready = 1'b0;
   logic [31:0] imem_addr, imem_instr = '0;
   logic [31:0] instr_ID, pc_ID, npc_ID;
   logic        valid_ID;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state
   logic [31:0] m_pc, m_npc, m_rt, m_instr, m_pcid, m_npcid;
   logic        m_rp, m_ap, m_vid;

   fetch_if_stage dut (
      .clk(clk), .rst_n(rst_n), .stall_F(stall_F), .stall_D(stall_D),
      .branch_taken(branch_taken), .branch_target(branch_target), .annul(annul),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_instr(imem_instr), .instr_ID(instr_ID), .pc_ID(pc_ID),
      .npc_ID(npc_ID), .valid_ID(valid_ID)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_npc = 32'h4; m_rt = '0; m_rp = 1'b0; m_ap = 1'b0;
      m_instr = NOP; m_pcid = '0; m_npcid = '0; m_vid = 1'b0;
   endtask

   task automatic check_id(input string tag);
      check({tag, "_valid"}, {31'b0, valid_ID}, {31'b0, m_vid});
      check({tag, "_instr"}, instr_ID, m_instr);
      if (m_vid) begin
         check({tag, "_pc"},  pc_ID,  m_pcid);
         check({tag, "_npc"}, npc_ID, m_npcid);
      end
   endtask

   // One clock cycle: drive, check fetch side, take the edge, update model, check ID side.
   task automatic step(input logic sf, input logic sd, input logic bt, input logic an,
                       input logic rdy, input logic [31:0] tgt);
      logic [31:0] w;
      logic [31:0] dest;
      logic        keep;
      w = $urandom;
      stall_F = sf; stall_D = sd; branch_taken = bt; annul = an;
      imem_ready = rdy; branch_target = tgt; imem_instr = w;
      #1;
      check("imem_req",  {31'b0, imem_req}, {31'b0, ~(sf | sd)});
      check("imem_addr", imem_addr, m_pc);
      @(posedge clk);
      if (!(sf | sd)) begin
         if (rdy) begin
            keep    = !(an || m_ap);
            m_instr = keep ? w : NOP;
            m_vid   = keep;
            m_pcid  = m_pc;
            m_npcid = m_npc;
            if (bt)        dest = tgt;
            else if (m_rp) dest = m_rt;
            else           dest = m_npc;
            m_pc  = dest;
            m_npc = dest + 32'd4;
            m_rp  = 1'b0;
            m_ap  = 1'b0;
         end else begin
            m_instr = NOP;
            m_vid   = 1'b0;
            if (bt) begin m_rp = 1'b1; m_rt = tgt; end
            if (an) m_ap = 1'b1;
         end
      end
      #1;
      check_id("id");
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req"},   {31'b0, imem_req}, 32'h0);
      check({tag, "_addr"},  imem_addr, 32'h0);
      check({tag, "_instr"}, instr_ID, NOP);
      check({tag, "_pc"},    pc_ID, 32'h0);
      check({tag, "_npc"},   npc_ID, 32'h0);
      check({tag, "_valid"}, {31'b0, valid_ID}, 32'h0);
   endtask

   initial begin
      model_reset();
      #12;
      check_reset_outputs("rst");
      @(posedge clk); #1 rst_n = 1'b1;

      // T1: sequential fetch from reset
      check("t1_valid0", {31'b0, valid_ID}, 32'h0);
      check("t1_addr0", imem_addr, 32'h0);
      step(0, 0, 0, 0, 1, 0);
      check("t1_pcid", pc_ID, 32'h0);
      check("t1_npcid", npc_ID, 32'h4);
      check("t1_addr1", imem_addr, 32'h4);
      step(0, 0, 0, 0, 1, 0);
      check("t1_addr2", imem_addr, 32'h8);
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 1, 0);

      // T2: full freeze at 0x10; branch/annul/ready ignored while held
      check("t2_addr", imem_addr, 32'h10);
      step(1, 1, 1, 1, 1, 32'h400);
      step(1, 1, 0, 0, 1, 0);
      check("t2_hold_addr", imem_addr, 32'h10);
      check("t2_hold_pcid", pc_ID, 32'hC);
      step(0, 0, 0, 0, 1, 0);
      check("t2_resume_pcid", pc_ID, 32'h10);

      // T3: branch with live delay slot at 0x14
      step(0, 0, 1, 0, 1, 32'h100);
      check("t3_slot_valid", {31'b0, valid_ID}, 32'h1);
      check("t3_slot_pc", pc_ID, 32'h14);
      check("t3_redir", imem_addr, 32'h100);
      step(0, 0, 0, 0, 1, 0);
      check("t3_npcid", npc_ID, 32'h104);

      // T4: branch + annul squashes the delay slot
      step(0, 0, 1, 1, 1, 32'h100);
      check("t4_nop", instr_ID, NOP);
      check("t4_valid", {31'b0, valid_ID}, 32'h0);
      check("t4_redir", imem_addr, 32'h100);
      step(0, 0, 1, 0, 1, 32'h20);

      // T5: three wait cycles at 0x20 with a pending redirect + annul
      check("t5_addr", imem_addr, 32'h20);
      step(0, 0, 1, 1, 0, 32'h200);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      check("t5_pcid", pc_ID, 32'h20);
      check("t5_valid", {31'b0, valid_ID}, 32'h0);
      check("t5_redir", imem_addr, 32'h200);

      // Later redirect in the same wait overwrites the first
      step(0, 0, 1, 0, 0, 32'h500);
      step(0, 0, 1, 0, 0, 32'h600);
      step(0, 0, 0, 0, 1, 0);
      check("ovw_redir", imem_addr, 32'h600);

      // nPC wraps past the top of the address space
      step(0, 0, 1, 0, 1, 32'hFFFF_FFFC);
      step(0, 0, 0, 0, 1, 0);
      check("wrap_npcid", npc_ID, 32'h0);
      check("wrap_addr", imem_addr, 32'h0);

      // T6: reset during a wait with a redirect pending
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 1, 0, 0, 32'h300);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("t6");
      model_reset();
      @(posedge clk); #1 rst_n = 1'b1;
      step(0, 0, 0, 0, 1, 0);
      check("t6_restart_pc", pc_ID, 32'h0);
      check("t6_restart_addr", imem_addr, 32'h4);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 99) < 10, $urandom_range(0, 99) < 8,
              $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10,
              $urandom_range(0, 99) < 70, {$urandom_range(0, 32'h3FFF), 2'b00});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
